power_spectrum_buffer: RTL

POWER_SPECTRUM_BUFFER -- requirements
Module: power_spectrum_buffer

---
 rtl/power_spectrum_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/power_spectrum_buffer.sv
// ============================================================================
// Module      : power_spectrum_buffer
// Description : Ping-pong frame buffer between the power-spectrum stage and
//               the mel filterbank stage, with a synchronous random-read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module power_spectrum_buffer #(
   parameter int NFFT       = 257,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ps_valid_i,
   input  logic [DATA_WIDTH-1:0]     ps_data_i,
   output logic                      ps_ready_o,
   output logic                      mel_start_o,
   input  logic                      mel_done_i,
   input  logic [$clog2(NFFT):0]     rd_addr_i,
   output logic [DATA_WIDTH-1:0]     rd_data_o,
   output logic [1:0]                frames_ready_o
);

   localparam int IW = $clog2(NFFT);
   localparam int AW = IW + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NFFT - 1);
   localparam logic [AW-1:0] NFFT_A   = AW'(NFFT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } state_t;

   logic [DATA_WIDTH-1:0] bank0 [0:NFFT-1];
   logic [DATA_WIDTH-1:0] bank1 [0:NFFT-1];

   state_t        state;
   logic [IW-1:0] wr_idx;
   logic          wr_bank;
   logic          rd_bank;
   logic [1:0]    count;

   logic          accept;
   logic          frame_done;
   logic          release_bank;

   assign ps_ready_o     = (count < 2'd2);
   assign accept         = ps_valid_i & ps_ready_o;
   assign frame_done     = accept & (wr_idx == LAST_IDX);
   assign release_bank   = (state == BUSY) & mel_done_i;
   assign frames_ready_o = count;

   // Bank storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (wr_bank)
            bank1[wr_idx] <= ps_data_i;
         else
            bank0[wr_idx] <= ps_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx  <= '0;
         wr_bank <= 1'b0;
      end else if (accept) begin
         if (frame_done) begin
            wr_idx  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_idx  <= wr_idx + IW'(1);
         end
      end
   end

   // Completion and release on the same edge cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
      end else begin
         case ({frame_done, release_bank})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rd_bank     <= 1'b0;
         mel_start_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (count != 2'd0) begin
                  state       <= START;
                  mel_start_o <= 1'b1;
               end else begin
                  mel_start_o <= 1'b0;
               end
            end
            START: begin
               state       <= BUSY;
               mel_start_o <= 1'b0;
            end
            BUSY: begin
               mel_start_o <= 1'b0;
               if (mel_done_i) begin
                  rd_bank <= ~rd_bank;
                  state   <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               mel_start_o <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_o <= '0;
      end else if (rd_addr_i < NFFT_A) begin
         rd_data_o <= rd_bank ? bank1[rd_addr_i[IW-1:0]] : bank0[rd_addr_i[IW-1:0]];
      end else begin
         rd_data_o <= '0;
      end
   end

endmodule

`default_nettype wire
